// File: rtl/accu_pkg.sv
// Shared defaults, mode encodings and width helper for the multi-channel
// windowed accumulator.
package accu_pkg;

    localparam int IN_W_DEF    = 32;
    localparam int N_CH_DEF    = 4;
    localparam int MAX_WIN_DEF = 50;

    localparam logic MODE_DUMP = 1'b0;
    localparam logic MODE_RUN  = 1'b1;

    // Ceiling log2, floored at one bit so a degenerate range still has a port.
    function automatic int clog2_min1(input int v);
        return ($clog2(v) < 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/accu_ch_state.sv
// State of one channel: running sum, sample count and the window length /
// mode captured when the channel's current window opened.
module accu_ch_state
    import accu_pkg::*;
#(
    parameter int OUT_W = 38,
    parameter int CNT_W = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    upd,
    input  logic                    start,
    input  logic                    done,
    input  logic signed [OUT_W-1:0] sum,
    input  logic        [CNT_W-1:0] win_in,
    input  logic                    mode_in,
    output logic signed [OUT_W-1:0] acc_q,
    output logic        [CNT_W-1:0] cnt_q,
    output logic        [CNT_W-1:0] win_q,
    output logic                    mode_q
);

    logic signed [OUT_W-1:0] acc_d;
    logic        [CNT_W-1:0] cnt_d;
    logic        [CNT_W-1:0] win_d;
    logic                    mode_d;
    logic                    mode_eff;

    // The mode that governs this sample is the fresh one when a window opens.
    assign mode_eff = start ? mode_in : mode_q;

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        win_d  = win_q;
        mode_d = mode_q;
        if (upd) begin
            if (start) begin
                win_d  = win_in;
                mode_d = mode_in;
            end
            if (done) begin
                cnt_d = '0;
                acc_d = (mode_eff == MODE_DUMP) ? '0 : sum;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            win_q  <= '0;
            mode_q <= MODE_DUMP;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            win_q  <= win_d;
            mode_q <= mode_d;
        end
    end

endmodule

// File: rtl/accu_win_mc.sv
// Multi-channel windowed accumulator: one shared adder indexed by the sample's
// channel, per-channel state banks, a registered output word and a sticky error.
module accu_win_mc
    import accu_pkg::*;
#(
    parameter int IN_W    = IN_W_DEF,
    parameter int N_CH    = N_CH_DEF,
    parameter int MAX_WIN = MAX_WIN_DEF,
    parameter int CNT_W   = clog2_min1(MAX_WIN + 1),
    parameter int CH_W    = clog2_min1(N_CH),
    parameter int OUT_W   = IN_W + $clog2(MAX_WIN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    din_valid,
    input  logic        [CH_W-1:0]  din_ch,
    input  logic signed [IN_W-1:0]  din,
    input  logic        [CNT_W-1:0] win_len,
    input  logic                    mode,
    output logic signed [OUT_W-1:0] dout,
    output logic        [CH_W-1:0]  dout_ch,
    output logic                    dout_valid,
    output logic                    cfg_err
);

    localparam logic [CH_W:0]    N_CH_V    = (CH_W + 1)'(N_CH);
    localparam logic [CNT_W-1:0] MAX_WIN_V = CNT_W'(MAX_WIN);

    logic signed [OUT_W-1:0] acc_arr  [N_CH];
    logic        [CNT_W-1:0] cnt_arr  [N_CH];
    logic        [CNT_W-1:0] win_arr  [N_CH];
    logic                    mode_arr [N_CH];

    logic                    live;
    logic                    ch_ok;
    logic                    acc_ok;
    logic                    bad_ch;
    logic        [CH_W-1:0]  sel;
    logic                    len_ok;
    logic        [CNT_W-1:0] eff_len;
    logic                    start;
    logic        [CNT_W-1:0] win_eff;
    logic                    mode_eff;
    logic signed [OUT_W-1:0] base;
    logic signed [OUT_W-1:0] sum;
    logic        [CNT_W:0]   cnt_inc;
    logic                    done;

    logic signed [OUT_W-1:0] dout_d,       dout_q;
    logic        [CH_W-1:0]  dout_ch_d,    dout_ch_q;
    logic                    dout_valid_d, dout_valid_q;
    logic                    cfg_err_d,    cfg_err_q;

    // en is active-low: a high level freezes the block and ignores din.
    assign live   = din_valid && !en;
    assign ch_ok  = {1'b0, din_ch} < N_CH_V;
    assign acc_ok = live && ch_ok;
    assign bad_ch = live && !ch_ok;
    assign sel    = ch_ok ? din_ch : '0;

    assign len_ok  = (win_len != '0) && (win_len <= MAX_WIN_V);
    assign eff_len = len_ok ? win_len : MAX_WIN_V;

    // A window opens on the first sample after a completion or reset.
    assign start    = (cnt_arr[sel] == '0);
    assign win_eff  = start ? eff_len : win_arr[sel];
    assign mode_eff = start ? mode : mode_arr[sel];
    assign base     = (start && (mode_eff == MODE_DUMP)) ? '0 : acc_arr[sel];
    assign sum      = base + OUT_W'(din);
    assign cnt_inc  = {1'b0, cnt_arr[sel]} + (CNT_W + 1)'(1);
    assign done     = (cnt_inc == {1'b0, win_eff});

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            accu_ch_state #(
                .OUT_W (OUT_W),
                .CNT_W (CNT_W)
            ) u_state (
                .clk     (clk),
                .rst     (rst),
                .upd     (acc_ok && (sel == CH_W'(gi))),
                .start   (start),
                .done    (done),
                .sum     (sum),
                .win_in  (eff_len),
                .mode_in (mode),
                .acc_q   (acc_arr[gi]),
                .cnt_q   (cnt_arr[gi]),
                .win_q   (win_arr[gi]),
                .mode_q  (mode_arr[gi])
            );
        end
    endgenerate

    always_comb begin
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_valid_d = 1'b0;
        cfg_err_d    = cfg_err_q || bad_ch || (acc_ok && start && !len_ok);
        if (acc_ok && done) begin
            dout_d       = sum;
            dout_ch_d    = din_ch;
            dout_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = dout_valid_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_accu_win_mc.sv
// Bench for accu_win_mc: a window-level reference model checked every cycle,
// plus directed scenarios with hand-computed pulse values.
module tb_accu_win_mc;

    localparam int IN_W    = 32;
    localparam int N_CH    = 5;
    localparam int MAX_WIN = 50;
    localparam int CNT_W   = 6;
    localparam int CH_W    = 3;
    localparam int OUT_W   = 38;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    en = 1'b0;
    logic                    din_valid = 1'b0;
    logic        [CH_W-1:0]  din_ch = '0;
    logic signed [IN_W-1:0]  din = '0;
    logic        [CNT_W-1:0] win_len = CNT_W'(1);
    logic                    mode = 1'b0;
    logic signed [OUT_W-1:0] dout;
    logic        [CH_W-1:0]  dout_ch;
    logic                    dout_valid;
    logic                    cfg_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int                 ch;
        logic signed [63:0] v;
    } pulse_t;
    pulse_t got_q[$];

    // Reference state: samples collected in the open window of each channel.
    int                      m_n     [N_CH];
    int                      m_win   [N_CH];
    bit                      m_mode  [N_CH];
    logic signed [OUT_W-1:0] m_wsum  [N_CH];
    logic signed [OUT_W-1:0] m_carry [N_CH];
    logic                    m_valid = 1'b0;
    logic signed [OUT_W-1:0] m_dout = '0;
    logic        [CH_W-1:0]  m_ch = '0;
    logic                    m_err = 1'b0;

    accu_win_mc #(
        .IN_W    (IN_W),
        .N_CH    (N_CH),
        .MAX_WIN (MAX_WIN),
        .CNT_W   (CNT_W),
        .CH_W    (CH_W),
        .OUT_W   (OUT_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din_valid  (din_valid),
        .din_ch     (din_ch),
        .din        (din),
        .win_len    (win_len),
        .mode       (mode),
        .dout       (dout),
        .dout_ch    (dout_ch),
        .dout_valid (dout_valid),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic signed [OUT_W-1:0] total;
        int c;
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                m_n[i] = 0; m_win[i] = 0; m_mode[i] = 1'b0;
                m_wsum[i] = '0; m_carry[i] = '0;
            end
            m_valid = 1'b0; m_dout = '0; m_ch = '0; m_err = 1'b0;
            return;
        end
        m_valid = 1'b0;
        if (din_valid && !en) begin
            c = int'(din_ch);
            if (c >= N_CH) begin
                m_err = 1'b1;
            end else begin
                if (m_n[c] == 0) begin
                    if (int'(win_len) >= 1 && int'(win_len) <= MAX_WIN) begin
                        m_win[c] = int'(win_len);
                    end else begin
                        m_win[c] = MAX_WIN;
                        m_err = 1'b1;
                    end
                    m_mode[c] = mode;
                    m_wsum[c] = '0;
                end
                m_wsum[c] = m_wsum[c] + OUT_W'(din);
                m_n[c]++;
                if (m_n[c] == m_win[c]) begin
                    total = (m_mode[c] ? m_carry[c] : '0) + m_wsum[c];
                    m_carry[c] = m_mode[c] ? total : '0;
                    m_valid = 1'b1;
                    m_dout = total;
                    m_ch = CH_W'(c);
                    m_n[c] = 0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    always @(negedge clk) begin
        chk("dout_valid", dout_valid, m_valid);
        chk("dout", dout, m_dout);
        chk("dout_ch", dout_ch, m_ch);
        chk("cfg_err", cfg_err, m_err);
        if (dout_valid === 1'b1) got_q.push_back('{int'(dout_ch), dout});
    end

    task automatic send(input int ch, input longint d);
        din_valid = 1'b1;
        din_ch = CH_W'(ch);
        din = IN_W'(d);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_pulse(input string name, input int idx, input int ch,
                             input longint v);
        pulse_t p;
        p = '{-1, 64'sd0};
        if (idx < got_q.size()) p = got_q[idx];
        chk({name, "_ch"}, p.ch, ch);
        chk({name, "_val"}, p.v, v);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_err", cfg_err, 0);

        // 1: window 50 on one channel, two back-to-back windows of ones
        win_len = CNT_W'(50); mode = 1'b0;
        for (int i = 0; i < 100; i++) send(0, 1);
        idle(2);
        chk("t1_count", got_q.size(), 2);
        chk_pulse("t1_p0", 0, 0, 50);
        chk_pulse("t1_p1", 1, 0, 50);
        got_q.delete();

        // 2: four channels round-robin, window 3, dump
        win_len = CNT_W'(3);
        for (int i = 0; i < 12; i++) send(i % 4, (i % 4) + 1);
        idle(2);
        chk("t2_count", got_q.size(), 4);
        for (int k = 0; k < 4; k++) chk_pulse("t2_p", k, k, 3 * (k + 1));
        got_q.delete();

        // 3: running window 2 of -5, then dump requested mid-window
        win_len = CNT_W'(2); mode = 1'b1;
        for (int i = 0; i < 7; i++) send(1, -5);
        mode = 1'b0;
        for (int i = 0; i < 3; i++) send(1, -5);
        idle(2);
        chk("t3_count", got_q.size(), 5);
        chk_pulse("t3_p0", 0, 1, -10);
        chk_pulse("t3_p1", 1, 1, -20);
        chk_pulse("t3_p2", 2, 1, -30);
        chk_pulse("t3_p3", 3, 1, -40);
        chk_pulse("t3_p4", 4, 1, -10);
        got_q.delete();

        // 4: hold via en while samples keep arriving; pulse survives en rising
        win_len = CNT_W'(4);
        send(2, 10); send(2, 10);
        en = 1'b1;
        for (int i = 0; i < 5; i++) send(2, 100);
        en = 1'b0;
        send(2, 10); send(2, 10);
        win_len = CNT_W'(1);
        send(3, 7);
        en = 1'b1;
        for (int i = 0; i < 3; i++) send(3, 100);
        en = 1'b0;
        idle(2);
        chk("t4_count", got_q.size(), 2);
        chk_pulse("t4_p0", 0, 2, 40);
        chk_pulse("t4_p1", 1, 3, 7);
        got_q.delete();

        // 5: bad channel, bad window length, then reset clears everything
        rst = 1'b1; idle(1); rst = 1'b0;
        send(5, 1000);
        chk("t5_badch_err", cfg_err, 1);
        idle(1);
        chk("t5_badch_nopulse", got_q.size(), 0);
        rst = 1'b1; idle(1); rst = 1'b0;
        chk("t5_rst_err", cfg_err, 0);
        win_len = '0;
        send(0, 1);
        chk("t5_len_err", cfg_err, 1);
        win_len = CNT_W'(3);
        for (int i = 0; i < 24; i++) send(0, 1);
        send(7, 1000);
        for (int i = 0; i < 25; i++) send(0, 1);
        idle(2);
        chk("t5_count", got_q.size(), 1);
        chk_pulse("t5_p0", 0, 0, 50);
        got_q.delete();
        rst = 1'b1; idle(1); rst = 1'b0;
        chk("t5_rst_dout", dout, 0);
        chk("t5_rst_ch", dout_ch, 0);
        chk("t5_rst_valid", dout_valid, 0);
        chk("t5_rst_err2", cfg_err, 0);

        // 6: full-scale positive samples, then reset mid-window
        win_len = CNT_W'(50); mode = 1'b0;
        for (int i = 0; i < 50; i++) send(0, 64'sd2147483647);
        for (int i = 0; i < 19; i++) send(0, 64'sd2147483647);
        rst = 1'b1; send(0, 64'sd2147483647); rst = 1'b0;
        idle(1);
        for (int i = 0; i < 50; i++) send(0, 1);
        idle(2);
        chk("t6_count", got_q.size(), 2);
        chk_pulse("t6_p0", 0, 0, 64'sd107374182350);
        chk_pulse("t6_p1", 1, 0, 50);
        got_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/accu_win_mc.md
Name: accu_win_mc

Overview:
- Multi-channel windowed accumulator. Parametrised successor of the single-channel fixed-50 accumulator.
- Accepts time-multiplexed signed samples tagged with a channel index. Keeps one accumulator and one sample counter per channel.
- Emits a one-cycle-valid windowed sum per channel every win_len accepted samples of that channel.
- Sits between the feature datapath and the FIFO block. Supports dump mode (clear per window) and running mode (never clears).

Parameters:
- IN_W, 32: signed input sample width.
- N_CH, 4: number of channels (>=1).
- MAX_WIN, 50: maximum window length in samples (>=1).
- CNT_W, $clog2(MAX_WIN+1): width of win_len and the counters.
- CH_W, (N_CH>1 ? $clog2(N_CH) : 1): channel index width.
- OUT_W, IN_W+$clog2(MAX_WIN): output sum width.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous reset, active-high.
- en, in, 1: active-low enable. High means hold all state and ignore input.
- din_valid, in, 1: sample strobe.
- din_ch, in, CH_W: channel of din.
- din, in, IN_W: signed sample.
- win_len, in, CNT_W: window length. Latched per channel at window start.
- mode, in, 1: 0 = dump, 1 = running. Latched per channel at window start.
- dout, out, OUT_W: signed windowed sum.
- dout_ch, out, CH_W: channel of dout.
- dout_valid, out, 1: one-cycle pulse marking dout/dout_ch valid.
- cfg_err, out, 1: sticky error flag. Set on bad win_len or bad din_ch.

Behaviour:
- One clock and one reset: rst is synchronous and active-high; all state lives in the clk domain.
- Reset values: every acc, cnt, win_reg and mode_reg = 0; dout = 0; dout_ch = 0; dout_valid = 0; cfg_err = 0.
- Reset mid-window discards partial sums; no output is produced for them.
- Accept condition: din_valid && !en && din_ch < N_CH.
- Bad channel: din_valid && !en && din_ch >= N_CH → sample dropped, cfg_err <= 1, no state change.
- Window start: an accepted sample with cnt[ch] == 0.
  - win_reg[ch] <= eff_len and mode_reg[ch] <= mode.
  - eff_len = win_len if 1 <= win_len <= MAX_WIN. Otherwise eff_len = MAX_WIN and cfg_err <= 1.
  - Later changes to win_len/mode do not affect a channel mid-window.
- Sum on each accepted sample:
  - s = base + sign-extend(din) to OUT_W.
  - base = 0 if cnt==0 && latched-mode==dump; otherwise base = acc[ch].
  - Running mode wraps two's complement at OUT_W with no saturation.
  - Dump mode cannot overflow, by construction of OUT_W.
- Window completion: cnt[ch]+1 == win_eff, where win_eff = eff_len at window start and win_reg[ch] otherwise.
  - Next cycle: dout <= s, dout_ch <= din_ch, dout_valid <= 1. Latency 1 cycle from the completing sample.
  - cnt[ch] <= 0.
  - acc[ch] <= 0 in dump mode; acc[ch] <= s in running mode.
- Non-completing accepted sample: acc[ch] <= s, cnt[ch] <= cnt[ch]+1.
- The completing sample is included in its window. The next accepted sample starts the new window, so no sample is lost or double-counted.
- Window length 1: every accepted sample produces an output.
- dout_valid is high for exactly one cycle per completion, otherwise low. dout/dout_ch hold their last value when dout_valid is low.
- Back-to-back completions on consecutive cycles (any channels) each give their own pulse. No output backpressure: the consumer must accept one word per cycle.
- en high: acc/cnt/cfg regs hold and input is ignored. A pulse registered on the previous cycle still appears. dout_valid is 0 on the following cycles.
- Only one sample arrives per cycle, so there are no same-channel collisions. The shared adder is indexed by din_ch.

Decomposition:
- Package accu_pkg holds:
  - defaults IN_W/N_CH/MAX_WIN;
  - the MODE_DUMP=1'b0 and MODE_RUN=1'b1 constants;
  - a clog2-based width helper function.
- One sub-module, accu_ch_state: per-channel acc/cnt/win_reg/mode_reg registers with load/clear controls, generated N_CH times.
- The top level holds the channel mux, shared adder, completion compare, output register and cfg_err.

Test Plan:
1. N_CH=1, win_len=50, dump, din=1 for 100 samples → two pulses, each dout=50, on the cycle after samples 50 and 100; cnt restarts with no lost sample.
2. 4 channels round-robin, win_len=3, ch k din=k+1, dump → every 12 samples, 4 pulses with dout_ch=0..3 and dout=3,6,9,12.
3. Running mode, win_len=2, din=-5 repeatedly → dout=-10, -20, -30; then switch mode to dump mid-window → the change takes effect only after the current window completes.
4. en held high for 5 cycles mid-window with din_valid=1 → no state change; after en goes low, the window completes with the sum of accepted samples only.
5. win_len=0, then din_ch=5 with N_CH=4 → cfg_err=1, window uses MAX_WIN=50, bad-channel sample dropped; rst → cfg_err=0, all outputs 0.
6. din=2^(IN_W-1)-1 for MAX_WIN samples in dump mode → exact sum with no wrap. Assert rst at sample 20 → no pulse, and the next window counts from 0.
